// File: rtl/nn_acc_pkg.sv
// Shared definitions for the neural-network partial-sum accumulator.
// Holds the default widths, the FSM state encoding and the signed
// range limits of the aggregated sum.
package nn_acc_pkg;

    localparam int unsigned DEF_DATA_W    = 6;
    localparam int unsigned DEF_AGG_WIDTH = 12;
    localparam int unsigned DEF_ACC_W     = 16;
    localparam int unsigned DEF_N_TERMS   = 16;

    // Signed range of an aggregated sum.
    localparam int SAT_MAX = (1 <<< (DEF_AGG_WIDTH - 1)) - 1;
    localparam int SAT_MIN = -(1 <<< (DEF_AGG_WIDTH - 1));

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } psum_state_e;

endpackage

// File: rtl/psum_clamp.sv
// Narrows an ACC_W-bit signed accumulator to an AGG_WIDTH-bit sum.
// Build option: PSUM_SAT_EN defined -> clamp to the signed AGG_WIDTH range,
// undefined -> two's-complement wrap (low AGG_WIDTH bits).
// Ports:
//   acc    : signed accumulator value
//   data_c : narrowed sum (combinational)
//   sat_c  : acc lies outside the AGG_WIDTH signed range (same in both builds)
module psum_clamp #(
    parameter int unsigned ACC_W     = 16,
    parameter int unsigned AGG_WIDTH = 12
) (
    input  logic [ACC_W-1:0]     acc,
    output logic [AGG_WIDTH-1:0] data_c,
    output logic                 sat_c
);

    localparam int unsigned TOP_W = ACC_W - AGG_WIDTH + 1;

    // In range iff every bit from the AGG sign bit upward matches.
    logic [TOP_W-1:0] top;
    assign top   = acc[ACC_W-1:AGG_WIDTH-1];
    assign sat_c = !((&top) || !(|top));

`ifdef PSUM_SAT_EN
    logic [AGG_WIDTH-1:0] lim;
    assign lim    = acc[ACC_W-1] ? {1'b1, {(AGG_WIDTH-1){1'b0}}}
                                 : {1'b0, {(AGG_WIDTH-1){1'b1}}};
    assign data_c = sat_c ? lim : acc[AGG_WIDTH-1:0];
`else
    assign data_c = acc[AGG_WIDTH-1:0];
`endif

endmodule

// File: rtl/psum_acc.sv
// Partial-sum producer: multiply-accumulates signed (x, w) beats and emits
// one AGG_WIDTH-bit sum per neuron over a ready/valid handshake.
// A neuron closes on in_last or automatically on its N_TERMS-th beat.
// Build option: PSUM_SAT_EN selects clamping instead of wrapping (psum_clamp).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input beat handshake
//   in_x, in_w, in_last : signed activation, signed weight, end of neuron
//   out_valid/out_ready : result handshake
//   out_data            : signed sum, zero whenever no result is held
//   out_sat             : sum was clipped or wrapped
//   out_cnt             : number of beats in the sum
module psum_acc
    import nn_acc_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned AGG_WIDTH = DEF_AGG_WIDTH,
    parameter int unsigned N_TERMS   = DEF_N_TERMS,
    parameter int unsigned ACC_W     = DEF_ACC_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_W-1:0]      in_x,
    input  logic signed [DATA_W-1:0]      in_w,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [AGG_WIDTH-1:0]          out_data,
    output logic                          out_sat,
    output logic [$clog2(N_TERMS):0]      out_cnt
);

    localparam int unsigned CNT_W  = $clog2(N_TERMS) + 1;
    localparam int unsigned PROD_W = 2 * DATA_W;

    psum_state_e                state_q, state_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       in_ready_d, out_valid_d, out_sat_d;
    logic [AGG_WIDTH-1:0]       out_data_d;
    logic [CNT_W-1:0]           out_cnt_d;

    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    acc_sum;
    logic [AGG_WIDTH-1:0]       clamp_data;
    logic                       clamp_sat;
    logic                       accept;
    logic                       close;

    // Full-width product, sign-extended into the accumulator.
    assign prod    = in_x * in_w;
    assign acc_sum = ((cnt_q == '0) ? ACC_W'(0) : acc_q) + ACC_W'(prod);
    assign accept  = in_valid && in_ready;
    assign close   = in_last || (cnt_q == CNT_W'(N_TERMS - 1));

    psum_clamp #(
        .ACC_W     (ACC_W),
        .AGG_WIDTH (AGG_WIDTH)
    ) u_clamp (
        .acc    (acc_sum),
        .data_c (clamp_data),
        .sat_c  (clamp_sat)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_sat_d   = out_sat;
        out_cnt_d   = out_cnt;
        case (state_q)
            ACC: begin
                if (accept) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (close) begin
                        state_d     = HOLD;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        out_data_d  = clamp_data;
                        out_sat_d   = clamp_sat;
                        out_cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = ACC;
                    acc_d       = '0;
                    cnt_d       = '0;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                    out_sat_d   = 1'b0;
                    out_cnt_d   = '0;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_sat   <= out_sat_d;
            out_cnt   <= out_cnt_d;
        end
    end

endmodule
